// File: rtl/rectify.sv
// rectify: saturating-ReLU activation stage with a gated error return path.
// Forward pass clamps a signed Q8.8 sum into an unsigned Q0.8 activation and
// remembers whether the sum fell inside the linear region. The backward pass
// forwards the downstream error only when that region flag is set.
module rectify (
    input  logic        clock,
    input  logic        reset,
    input  logic        train,
    input  logic        arg_valid,
    input  logic [15:0] arg_data,
    output logic        arg_ready,
    output logic        res_valid,
    output logic [7:0]  res_data,
    input  logic        res_ready,
    input  logic        err_valid,
    input  logic [15:0] err_data,
    output logic        err_ready,
    output logic        fbk_valid,
    output logic [15:0] fbk_data,
    input  logic        fbk_ready
);

    typedef enum logic [1:0] {
        ARG = 2'd0,
        RES = 2'd1,
        ERR = 2'd2,
        FBK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  resData_q, resData_d;
    logic        slope_q, slope_d;
    logic [15:0] fbkData_q, fbkData_d;

    logic        sumNonPositive;
    logic        sumAboveRange;

    // The sum is non-positive when its sign bit is set or it is exactly zero;
    // it overflows the 8-bit activation when positive with any integer bit
    // above bit 7 set.
    always_comb begin
        sumNonPositive = arg_data[15] || (arg_data == 16'h0000);
        sumAboveRange  = !arg_data[15] && (|arg_data[14:8]);
    end

    // Next-state and data-register updates: each state waits for its own
    // handshake only, so stray valids in other states are ignored.
    always_comb begin
        state_d   = state_q;
        resData_d = resData_q;
        slope_d   = slope_q;
        fbkData_d = fbkData_q;
        case (state_q)
            ARG: begin
                if (arg_valid) begin
                    if (sumNonPositive) begin
                        resData_d = 8'h00;
                        slope_d   = 1'b0;
                    end else if (sumAboveRange) begin
                        resData_d = 8'hFF;
                        slope_d   = 1'b0;
                    end else begin
                        resData_d = arg_data[7:0];
                        slope_d   = 1'b1;
                    end
                    state_d = RES;
                end
            end
            RES: begin
                if (res_ready) begin
                    state_d = train ? ERR : ARG;
                end
            end
            ERR: begin
                if (err_valid) begin
                    fbkData_d = slope_q ? err_data : 16'h0000;
                    state_d   = FBK;
                end
            end
            FBK: begin
                if (fbk_ready) begin
                    state_d = ARG;
                end
            end
            default: begin
                state_d = ARG;
            end
        endcase
    end

    // State and data registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARG;
            resData_q <= 8'h00;
            slope_q   <= 1'b0;
            fbkData_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            resData_q <= resData_d;
            slope_q   <= slope_d;
            fbkData_q <= fbkData_d;
        end
    end

    // Handshake flags decode straight from the registered state, so the
    // valids are glitch-free and the readies never depend on input valids.
    always_comb begin
        arg_ready = (state_q == ARG);
        res_valid = (state_q == RES);
        err_ready = (state_q == ERR);
        fbk_valid = (state_q == FBK);
        res_data  = resData_q;
        fbk_data  = fbkData_q;
    end

endmodule
